// File: rtl/term_ram_sched.sv
// term_ram_sched: shares one registered RAM write port between a fire-and-forget
// FIFO-buffered requester A, a req/gnt requester B and a full-screen clear engine.
module term_ram_sched #(
  parameter logic [7:0] CLR_CHAR = 8'h20,
  parameter int ADDR_W = 10,
  parameter int AF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [7:0]        a_data,
  output logic              a_ovf,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [7:0]        b_data,
  output logic              b_gnt,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_d
);
  localparam int PW = $clog2(AF_DEPTH);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t r_state, w_state_nx;
  logic [ADDR_W-1:0] r_af_addr [AF_DEPTH];
  logic [7:0]        r_af_data [AF_DEPTH];
  logic [PW:0]       r_wp, r_rp;
  logic [ADDR_W-1:0] r_cnt;
  logic              w_empty, w_full, w_pop, w_push, w_drop, w_clr_go, w_iss;
  logic [ADDR_W-1:0] w_iss_addr;
  logic [7:0]        w_iss_data;
  assign w_empty  = r_wp == r_rp;
  assign w_full   = (r_wp[PW] != r_rp[PW]) && (r_wp[PW-1:0] == r_rp[PW-1:0]);
  assign w_drop   = a_valid && w_full && !w_pop;
  assign w_push   = a_valid && !w_drop;
  assign clr_busy = r_state == CLEAR;
  always_ff @(posedge clk)
    if (rst) r_state <= IDLE;
    else r_state <= w_state_nx;
  // Priority: clear engine, then clear request, then A FIFO, then B.
  always_comb begin
    w_state_nx = r_state;
    w_pop      = 1'b0;
    w_clr_go   = 1'b0;
    b_gnt      = 1'b0;
    w_iss      = 1'b0;
    w_iss_addr = r_cnt;
    w_iss_data = CLR_CHAR;
    if (r_state == CLEAR) begin
      w_iss      = 1'b1;
      w_state_nx = &r_cnt ? IDLE : CLEAR;
    end else if (clr_start) begin
      w_clr_go   = 1'b1;
      w_state_nx = CLEAR;
    end else if (!w_empty) begin
      w_pop      = 1'b1;
      w_iss      = 1'b1;
      w_iss_addr = r_af_addr[r_rp[PW-1:0]];
      w_iss_data = r_af_data[r_rp[PW-1:0]];
    end else if (b_req) begin
      b_gnt      = !rst;
      w_iss      = 1'b1;
      w_iss_addr = b_addr;
      w_iss_data = b_data;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_wp     <= '0;
      r_rp     <= '0;
      r_cnt    <= '0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_d    <= '0;
      a_ovf    <= 1'b0;
    end else begin
      if (w_push) begin
        r_af_addr[r_wp[PW-1:0]] <= a_addr;
        r_af_data[r_wp[PW-1:0]] <= a_data;
        r_wp <= r_wp + 1'b1;
      end
      if (w_pop) r_rp <= r_rp + 1'b1;
      // Counter wraps to 0 on the final clear write, ready for the next clear.
      r_cnt  <= (r_state == CLEAR) ? r_cnt + 1'b1 : '0;
      ram_we <= w_iss;
      if (w_iss) begin
        ram_addr <= w_iss_addr;
        ram_d    <= w_iss_data;
      end
      a_ovf <= w_drop | (a_ovf & !w_clr_go);
    end
endmodule

// File: tb/tb_term_ram_sched.sv
// tb_term_ram_sched: vector table, directed clear/overflow/reset sequences and
// random traffic, all cross-checked every cycle against a queue-based model.
module tb_term_ram_sched;
  logic clk = 1'b0, rst = 1'b0;
  logic a_valid = 1'b0, b_req = 1'b0, clr_start = 1'b0;
  logic [9:0] a_addr = '0, b_addr = '0;
  logic [7:0] a_data = '0, b_data = '0;
  logic a_ovf, b_gnt, clr_busy, ram_we;
  logic [9:0] ram_addr;
  logic [7:0] ram_d;

  term_ram_sched dut (
    .clk(clk), .rst(rst), .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data),
    .a_ovf(a_ovf), .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_gnt(b_gnt),
    .clr_start(clr_start), .clr_busy(clr_busy), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_d(ram_d)
  );

  always #5 clk = ~clk;

  int nchk = 0, nerr = 0;
  bit chk_en = 1'b0;

  typedef struct { logic [9:0] a; logic [7:0] d; } ent_t;
  ent_t q[$];
  bit m_clr = 1'b0, m_ovf = 1'b0, m_we = 1'b0;
  int m_cnt = 0;
  logic [9:0] m_addr = '0;
  logic [7:0] m_d = '0;

  logic s_we, s_gnt, s_busy, s_ovf;
  logic [9:0] s_addr;
  logic [7:0] s_d;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: sample outputs, compare against the model, advance model and DUT.
  task automatic cyc();
    bit gnt, iss, go, drop;
    logic [9:0] ia;
    logic [7:0] id;
    ent_t e;
    #1;
    s_we = ram_we; s_addr = ram_addr; s_d = ram_d;
    s_gnt = b_gnt; s_busy = clr_busy; s_ovf = a_ovf;
    gnt = !rst && !m_clr && !clr_start && q.size() == 0 && b_req;
    if (chk_en)
      chk("model", {s_we, s_we ? s_addr : 10'h0, s_we ? s_d : 8'h0, s_gnt, s_busy, s_ovf},
                   {m_we, m_we ? m_addr : 10'h0, m_we ? m_d : 8'h0, gnt, m_clr, m_ovf});
    if (rst) begin
      q.delete(); m_clr = 0; m_cnt = 0; m_we = 0; m_addr = '0; m_d = '0; m_ovf = 0;
    end else begin
      iss = 0; go = 0; ia = '0; id = '0;
      if (m_clr) begin
        iss = 1; ia = 10'(m_cnt); id = 8'h20; m_cnt++;
        if (m_cnt == 1024) m_clr = 0;
      end else if (clr_start) begin
        m_clr = 1; m_cnt = 0; go = 1;
      end else if (q.size() > 0) begin
        e = q.pop_front(); iss = 1; ia = e.a; id = e.d;
      end else if (b_req) begin
        iss = 1; ia = b_addr; id = b_data;
      end
      drop = a_valid && q.size() >= 4;
      if (a_valid && !drop) q.push_back('{a_addr, a_data});
      if (drop) m_ovf = 1;
      else if (go) m_ovf = 0;
      m_we = iss;
      if (iss) begin m_addr = ia; m_d = id; end
    end
    @(posedge clk);
    #1;
    a_valid = 0; clr_start = 0; rst = 0;
    if (gnt) b_req = 0;
  endtask

  typedef struct {
    logic av; logic [9:0] aa; logic [7:0] ad;
    logic br; logic [9:0] ba; logic [7:0] bd;
    logic we; logic [9:0] wa; logic [7:0] wd; logic gnt;
  } vec_t;
  vec_t tbl[9];

  initial begin
    int good, busy_bad, gnt_early, n, bad;
    bit found;
    tbl[0] = '{1, 10'h045, 8'h37, 0, 10'h000, 8'h00, 0, 10'h000, 8'h00, 0};
    tbl[1] = '{0, 10'h000, 8'h00, 0, 10'h000, 8'h00, 0, 10'h000, 8'h00, 0};
    tbl[2] = '{0, 10'h000, 8'h00, 0, 10'h000, 8'h00, 1, 10'h045, 8'h37, 0};
    tbl[3] = '{0, 10'h000, 8'h00, 0, 10'h000, 8'h00, 0, 10'h000, 8'h00, 0};
    tbl[4] = '{1, 10'h001, 8'h32, 0, 10'h3E0, 8'h41, 0, 10'h000, 8'h00, 0};
    tbl[5] = '{0, 10'h000, 8'h00, 1, 10'h3E0, 8'h41, 0, 10'h000, 8'h00, 0};
    tbl[6] = '{0, 10'h000, 8'h00, 1, 10'h3E0, 8'h41, 1, 10'h001, 8'h32, 1};
    tbl[7] = '{0, 10'h000, 8'h00, 0, 10'h000, 8'h00, 1, 10'h3E0, 8'h41, 0};
    tbl[8] = '{0, 10'h000, 8'h00, 0, 10'h000, 8'h00, 0, 10'h000, 8'h00, 0};

    @(posedge clk); #1;
    rst = 1; cyc();
    chk_en = 1;
    rst = 1; a_valid = 1; a_addr = 10'h123; b_req = 1; b_addr = 10'h0AA; clr_start = 1;
    cyc();
    chk("gnt_in_rst", s_gnt, 0);
    b_req = 0;
    cyc();
    chk("rst_state", {s_we, s_addr, s_d, s_busy, s_ovf, s_gnt}, 0);

    foreach (tbl[i]) begin
      a_valid = tbl[i].av; a_addr = tbl[i].aa; a_data = tbl[i].ad;
      b_req = tbl[i].br; b_addr = tbl[i].ba; b_data = tbl[i].bd;
      cyc();
      chk($sformatf("vec%0d", i), {s_we, s_we ? s_addr : 10'h0, s_we ? s_d : 8'h0, s_gnt},
          {tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].gnt});
    end

    good = 0; busy_bad = 0; gnt_early = 0;
    b_req = 1; b_addr = 10'h155; b_data = 8'h66;
    for (int k = 0; k <= 1030; k++) begin
      clr_start = (k == 0);
      if (k == 100 || k == 200 || k == 300) begin
        a_valid = 1; a_addr = 10'h010 + 10'((k / 100) - 1); a_data = 8'h41 + 8'((k / 100) - 1);
      end
      cyc();
      if (k >= 2 && k <= 1025 && s_we && s_addr == 10'(k - 2) && s_d == 8'h20) good++;
      if (k >= 1 && s_busy != (k <= 1024)) busy_bad++;
      if (s_gnt && k < 1028) gnt_early++;
      if (k >= 1026 && k <= 1028)
        chk("clr_a_drain", {s_we, s_addr, s_d}, {1'b1, 10'h010 + 10'(k - 1026), 8'h41 + 8'(k - 1026)});
      if (k == 1028) chk("b_after_drain", s_gnt, 1);
      if (k == 1029) chk("b_write", {s_we, s_addr, s_d}, {1'b1, 10'h155, 8'h66});
    end
    chk("clr_writes", good, 1024);
    chk("clr_busy_span", busy_bad, 0);
    chk("gnt_during_clr", gnt_early, 0);
    chk("ovf_clear_a", s_ovf, 0);

    n = 0;
    for (int k = 0; k <= 1035; k++) begin
      clr_start = (k == 0);
      if (k >= 10 && k <= 50 && k % 10 == 0) begin
        a_valid = 1; a_addr = 10'h100 + 10'(k / 10 - 1); a_data = 8'h50 + 8'(k / 10 - 1);
      end
      cyc();
      if (k >= 1026 && s_we) begin
        chk("ovf_order", {s_addr, s_d}, {10'h100 + 10'(n), 8'h50 + 8'(n)});
        n++;
      end
    end
    chk("ovf_count", n, 4);
    clr_start = 1; cyc();
    chk("ovf_set", s_ovf, 1);
    cyc();
    chk("ovf_cleared", {s_ovf, s_busy}, 2'b01);

    found = 0;
    for (int i = 0; i < 1100; i++) begin
      cyc();
      if (s_we && s_addr == 10'h200) begin found = 1; break; end
    end
    chk("reach_0x200", found, 1);
    rst = 1; cyc();
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (i == 0) chk("rst_mid_clr", {s_addr, s_d, s_ovf}, 0);
      if (s_we || s_busy) bad++;
    end
    chk("no_we_after_rst", bad, 0);
    a_valid = 1; a_addr = 10'h2AA; a_data = 8'h5A; cyc();
    cyc();
    chk("post_rst_t1", s_we, 0);
    cyc();
    chk("post_rst_t2", {s_we, s_addr, s_d}, {1'b1, 10'h2AA, 8'h5A});

    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom % 600) == 0;
      clr_start = ($urandom % 300) == 0;
      if ($urandom % 3 == 0) begin
        a_valid = 1; a_addr = 10'($urandom); a_data = 8'($urandom);
      end
      if (!b_req && $urandom % 4 == 0) begin
        b_req = 1; b_addr = 10'($urandom); b_data = 8'($urandom);
      end
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/term_ram_sched.md
TERM_RAM_SCHED -- requirements
Module: term_ram_sched

Write-port scheduler for the 1024x8 terminal character RAM. It shares one RAM write port between three sources:
- UART field writer (requester A, fire-and-forget);
- status writer (requester B, req/gnt handshake);
- an internal screen-clear engine.

Interface
Parameters:
REQ-001 CLR_CHAR, 8'h20, byte written by the clear engine.
REQ-002 ADDR_W, 10, RAM address width; RAM depth = 2^ADDR_W.
REQ-003 AF_DEPTH, 4, requester-A FIFO depth (power of 2).

Ports:
REQ-004 clk  in  1  single clock for all logic.
REQ-005 rst  in  1  synchronous reset, active-high.
REQ-006 a_valid  in  1  one-cycle pulse; A byte present.
REQ-007 a_addr  in  ADDR_W  A write address.
REQ-008 a_data  in  8  A write data.
REQ-009 a_ovf  out  1  sticky flag; an A byte was dropped.
REQ-010 b_req  in  1  B write request; held until granted.
REQ-011 b_addr  in  ADDR_W  B address; stable while b_req is high.
REQ-012 b_data  in  8  B data; stable while b_req is high.
REQ-013 b_gnt  out  1  combinational; B write accepted this cycle.
REQ-014 clr_start  in  1  one-cycle pulse; request a full clear.
REQ-015 clr_busy  out  1  clear engine active.
REQ-016 ram_we  out  1  registered RAM write enable.
REQ-017 ram_addr  out  ADDR_W  registered RAM write address.
REQ-018 ram_d  out  8  registered RAM write data.

Function
REQ-019 Control FSM has two states, IDLE and CLEAR; at most one RAM write is issued per cycle.
REQ-020 A FIFO push: an a_valid pulse pushes {a_addr, a_data} at the same edge, in any state.

REQ-021 A FIFO full:
- push while full and no pop that cycle: byte dropped, a_ovf set;
- push and pop in the same cycle while full: both accepted, no drop.

REQ-022 IDLE, cycle priority (only the first matching case applies):
- clr_start: enter CLEAR; no write issued this cycle;
- FIFO non-empty: pop head and issue it;
- b_req: assert b_gnt and issue B;
- otherwise: no write.

REQ-023 Issue timing: an issued write appears on ram_we/ram_addr/ram_d in the following cycle; ram_we is low in every cycle with no issue.
REQ-024 A latency: a_valid at cycle t, with IDLE, FIFO empty and no clr_start at t+1, gives ram_we high at t+2 with the same addr/data.
REQ-025 b_gnt is asserted for exactly one cycle per accepted B write; B is never granted while the FIFO is non-empty or in CLEAR.
REQ-026 CLEAR entry: a counter starts at 0; each CLEAR cycle issues {cnt, CLR_CHAR} and increments cnt.
REQ-027 CLEAR exit: after issuing address 2^ADDR_W-1, the FSM returns to IDLE; the counter does not wrap into a second pass.
REQ-028 clr_busy = (state == CLEAR).

REQ-029 Clear timing, for clr_start at cycle t:
- clr_busy high from t+1 to t+2^ADDR_W;
- ram_we high from t+2 to t+2^ADDR_W+1, with addresses 0 to 2^ADDR_W-1 ascending.

REQ-030 clr_start asserted while in CLEAR is ignored.
REQ-031 Accepted clr_start clears a_ovf, except when a drop occurs in that same cycle; the drop takes precedence.
REQ-032 A bytes received during CLEAR stay in the FIFO and drain in FIFO order immediately after CLEAR exits, before any B grant.
REQ-033 FIFO entries are never discarded except by rst.

Reset
REQ-034 While rst is high at an edge, next-cycle values are:
- state IDLE, FIFO empty, clear counter 0;
- ram_we 0, ram_addr 0, ram_d 0;
- clr_busy 0, a_ovf 0.
- b_gnt is held 0 while rst is high.
REQ-035 rst during CLEAR aborts the clear: no write is issued in any cycle after the reset edge until new requests arrive.
REQ-036 a_valid, b_req and clr_start coincident with rst are ignored.

Verification
REQ-037 A latency: a_valid at t with addr 0x045, data 0x37 -> ram_we=1, ram_addr=0x045, ram_d=0x37 at t+2 only.
REQ-038 Contention: b_req held with 0x3E0/0x41, and a_valid at t with 0x001/0x32 -> A written at t+2; b_gnt at t+2; B written at t+3.
REQ-039 Clear: clr_start at t -> 1024 consecutive writes of 0x20 to 0x000..0x3FF over t+2..t+1025; clr_busy falls at t+1025; b_gnt stays 0 during the clear.
REQ-040 Clear plus A: 3 a_valid pulses (0x010/0x41, 0x011/0x42, 0x012/0x43) during clear -> written in order at t+1026..t+1028 after the last clear write; a_ovf stays 0.
REQ-041 Overflow: 5 a_valid pulses during clear with depth 4 -> 5th byte never written; a_ovf=1; next clr_start returns a_ovf to 0.
REQ-042 Reset mid-clear: rst at clear address 0x200 -> no ram_we after the reset edge; clr_busy=0; a new a_valid is serviced at +2 cycles.
